sprite_queue: RTL and testbench
===============================

// Module: sprite_queue
// PURPOSE
//  Show-ahead FIFO of sprite draw commands between the command decoder (writer) and the
//  sprite distributor (reader). Holds one frame's draw list; flushed on frame swap.
//  Presents the head entry continuously; distributor pops with a 1-cycle dequeue pulse.
//  Gates the read side while the framebuffer clears so no sprite draws into a resetting buffer.
// PARAMETERS
//  DEPTH   64  entries; power of two, >= 2
//  AW      $clog2(DEPTH)  pointer width (derived, not overridden)
// PORTS
//  clock                    in   1   system clock
//  reset                    in   1   asynchronous, active-low reset
//  enq_valid                in   1   writer has a command this cycle
//  enq_ready                out  1   queue accepts (= !full)
//  enq_id                   in   8   sprite id
//  enq_x, enq_y             in   16  sprite position (each)
//  enq_scale                in   8   sprite scale
//  clear                    in   1   synchronous flush (frame swap)
//  hold                     in   1   framebuffer resetting; hides contents from reader
//  sprite_queue_dequeue     in   1   pop head (from distributor)
//  sprite_queue_is_empty    out  1   no entry visible to reader
//  sprite_queue_sprite_id   out  8   head id
//  sprite_queue_sprite_x    out  16  head x
//  sprite_queue_sprite_y    out  16  head y
//  sprite_queue_sprite_scale out 8   head scale
//  count                    out  AW+1 entries stored, 0..DEPTH
//  overflow                 out  1   sticky: enqueue attempted while full
// BEHAVIOUR
//  Reset (reset=0, async): wr_ptr=rd_ptr=0, count=0, overflow=0, enq_ready=1,
//   sprite_queue_is_empty=1, head fields=0. Storage contents not reset.
//  Pointers AW+1 bits; full = (ptr MSBs differ, low bits equal); empty = (ptrs equal).
//  Entry = {id,x,y,scale}, 48 bits, stored in register array, read combinationally at rd_ptr.
//  Enqueue: enq_valid && !full -> store at wr_ptr, wr_ptr+1 (wraps mod 2*DEPTH).
//   Entry visible on head outputs the cycle after the accepting edge (1-cycle latency).
//  Enqueue while full: dropped, overflow<=1; held until clear or reset.
//  Dequeue: sprite_queue_dequeue && !empty && !hold -> rd_ptr+1; new head (or is_empty=1)
//   visible the cycle after the edge. Distributor rule: one pulse per entry, never two
//   consecutive cycles; a second consecutive pulse is still honoured (no filtering).
//  Dequeue while empty or hold: ignored, no state change.
//  Simultaneous enq+deq, non-empty and non-full: both take effect, count unchanged.
//  Simultaneous enq+deq when full: dequeue taken, enqueue dropped (enq_ready was 0), overflow<=1.
//  Simultaneous enq+deq when empty: enqueue taken, dequeue ignored.
//  sprite_queue_is_empty = empty || hold (combinational from registered state + hold).
//  Head fields are driven from storage regardless of is_empty; reader must qualify with it.
//  clear: next edge wr_ptr=rd_ptr=0, count=0, overflow=0; overrides enq/deq that cycle.
//  count registered, updates same edge as pointers; equals wr_ptr-rd_ptr.
//  No state machine beyond pointers; no combinational path enq_* -> head outputs.
// STRUCTURE
//  sprite_pkg: typedef struct packed {logic[7:0] id; logic[15:0] x,y; logic[7:0] scale;}
//   sprite_entry_t; localparam SPRITE_QUEUE_DEPTH=64. Distributor and decoder import it.
//  Single module; storage may later be split into sprite_queue_mem (1W/1R async-read array)
//   if it moves to LUTRAM, with identical timing.
// TESTING
//  1 Reset mid-fill (3 entries) -> is_empty=1, count=0, overflow=0 same cycle, async.
//  2 Enqueue id=5,x=100,y=200,scale=64 -> next cycle is_empty=0, head=(5,100,200,64), count=1.
//  3 Fill 64 entries id=0..63 -> enq_ready=0; 65th enq -> overflow=1, count=64; drain with
//    pulses every other cycle -> ids 0..63 in order, then is_empty=1; pointers wrap cleanly.
//  4 count=10, enq+deq same cycle for 20 cycles -> count stays 10, FIFO order preserved.
//  5 hold=1 with count=4 -> is_empty=1, dequeue pulses ignored, count=4; hold=0 -> head unchanged.
//  6 clear with enq_valid and dequeue same cycle at count=7 -> count=0, is_empty=1, overflow=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite draw-command types for the decoder, queue and distributor.
package sprite_pkg;

  localparam int SPRITE_QUEUE_DEPTH = 64;
  localparam int SPRITE_ENTRY_W     = 48;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  scale;
  } sprite_entry_t;

endpackage

// File: rtl/sprite_queue.sv
// Show-ahead FIFO of sprite draw commands; head is read combinationally at rd_ptr and
// the reader side is masked while the framebuffer is being cleared (hold).
module sprite_queue
  import sprite_pkg::*;
#(
  parameter int DEPTH = SPRITE_QUEUE_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [7:0]    enq_id,
  input  logic [15:0]   enq_x,
  input  logic [15:0]   enq_y,
  input  logic [7:0]    enq_scale,
  input  logic          clear,
  input  logic          hold,
  input  logic          sprite_queue_dequeue,
  output logic          sprite_queue_is_empty,
  output logic [7:0]    sprite_queue_sprite_id,
  output logic [15:0]   sprite_queue_sprite_x,
  output logic [15:0]   sprite_queue_sprite_y,
  output logic [7:0]    sprite_queue_sprite_scale,
  output logic [AW:0]   count,
  output logic          overflow
);

  sprite_entry_t mem [DEPTH];

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [DEPTH-1:0] written_q, written_d;

  logic             full, empty, do_enq, do_deq, wr_en;
  logic [AW-1:0]    wr_idx, rd_idx;
  sprite_entry_t    head;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign do_enq = enq_valid && !full;
  assign do_deq = sprite_queue_dequeue && !empty && !hold;
  assign wr_en  = do_enq && !clear;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    written_d  = written_q;
    if (wr_en) written_d[wr_idx] = 1'b1;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (do_enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_deq) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_enq, do_deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (enq_valid && full) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      written_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      written_q  <= written_d;
    end
  end

  // Storage is deliberately unreset so it can move to LUTRAM unchanged.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= '{id: enq_id, x: enq_x, y: enq_y, scale: enq_scale};
  end

  // Never-written slots read as zero so the head is defined straight out of reset.
  assign head = written_q[rd_idx] ? mem[rd_idx] : '0;

  assign enq_ready                 = !full;
  assign sprite_queue_is_empty     = empty || hold;
  assign sprite_queue_sprite_id    = head.id;
  assign sprite_queue_sprite_x     = head.x;
  assign sprite_queue_sprite_y     = head.y;
  assign sprite_queue_sprite_scale = head.scale;
  assign count                     = count_q;
  assign overflow                  = overflow_q;

endmodule

// File: tb/tb_sprite_queue.sv
// Directed bench for sprite_queue: reset, show-ahead latency, full/overflow, wrap,
// simultaneous enq/deq, hold masking and clear priority.
module tb_sprite_queue;
  import sprite_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [7:0]  enq_id = '0;
  logic [15:0] enq_x = '0;
  logic [15:0] enq_y = '0;
  logic [7:0]  enq_scale = '0;
  logic        clear = 1'b0;
  logic        hold = 1'b0;
  logic        deq = 1'b0;
  logic        is_empty;
  logic [7:0]  h_id;
  logic [15:0] h_x;
  logic [15:0] h_y;
  logic [7:0]  h_scale;
  logic [6:0]  count;
  logic        overflow;

  int tests = 0;
  int failed = 0;

  sprite_queue #(.DEPTH(64)) dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_id(enq_id), .enq_x(enq_x), .enq_y(enq_y), .enq_scale(enq_scale),
    .clear(clear), .hold(hold),
    .sprite_queue_dequeue(deq),
    .sprite_queue_is_empty(is_empty),
    .sprite_queue_sprite_id(h_id),
    .sprite_queue_sprite_x(h_x),
    .sprite_queue_sprite_y(h_y),
    .sprite_queue_sprite_scale(h_scale),
    .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_enq(input logic v, input logic [7:0] id);
    enq_valid = v;
    enq_id    = id;
    enq_x     = 16'(id) * 16'd3;
    enq_y     = 16'(id) + 16'd1000;
    enq_scale = ~id;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_empty", is_empty, 1);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready", enq_ready, 1);
    chk("rst_head", {h_id, h_scale}, 0);
    tick();
    reset = 1'b1;
    tick();

    // 1: asynchronous reset mid-fill
    for (int i = 0; i < 3; i++) begin
      drive_enq(1, 8'(i + 1));
      tick();
    end
    drive_enq(0, 0);
    chk("t1_count3", count, 3);
    #2 reset = 1'b0;
    #1;
    chk("t1_async_empty", is_empty, 1);
    chk("t1_async_count", count, 0);
    chk("t1_async_ovf", overflow, 0);
    chk("t1_async_head", h_id, 0);
    tick();
    reset = 1'b1;
    tick();

    // 2: single enqueue, one-cycle visibility
    enq_valid = 1; enq_id = 5; enq_x = 100; enq_y = 200; enq_scale = 64;
    #1;
    chk("t2_no_comb_path", is_empty, 1);
    tick();
    enq_valid = 0;
    chk("t2_empty", is_empty, 0);
    chk("t2_id", h_id, 5);
    chk("t2_x", h_x, 100);
    chk("t2_y", h_y, 200);
    chk("t2_scale", h_scale, 64);
    chk("t2_count", count, 1);
    deq = 1; tick(); deq = 0;
    chk("t2_drained", is_empty, 1);
    chk("t2_count0", count, 0);

    // 3: fill to full, overflow, full enq+deq, drain with wrap
    for (int i = 0; i < 64; i++) begin
      drive_enq(1, 8'(i));
      tick();
    end
    chk("t3_ready0", enq_ready, 0);
    chk("t3_count64", count, 64);
    chk("t3_ovf0", overflow, 0);
    drive_enq(1, 99);
    tick();
    chk("t3_ovf1", overflow, 1);
    chk("t3_count_full", count, 64);
    deq = 1; tick(); drive_enq(0, 0); deq = 0;
    chk("t3_fulldeq_count", count, 63);
    chk("t3_fulldeq_head", h_id, 1);
    chk("t3_fulldeq_x", h_x, 3);
    tick();
    for (int i = 1; i < 64; i++) begin
      chk($sformatf("t3_drain_id%0d", i), h_id, i);
      deq = 1; tick(); deq = 0; tick();
    end
    chk("t3_empty", is_empty, 1);
    chk("t3_count_end", count, 0);
    chk("t3_ovf_sticky", overflow, 1);
    chk("t3_ready1", enq_ready, 1);

    // 4: steady-state enq+deq keeps count
    clear = 1; tick(); clear = 0;
    chk("t4_clear_ovf", overflow, 0);
    for (int i = 0; i < 10; i++) begin
      drive_enq(1, 8'(100 + i));
      tick();
    end
    chk("t4_count10", count, 10);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("t4_head%0d", k), h_id, 100 + k);
      drive_enq(1, 8'(110 + k));
      deq = 1;
      tick();
      chk($sformatf("t4_count%0d", k), count, 10);
    end
    drive_enq(0, 0); deq = 0;
    chk("t4_head_end", h_id, 120);
    chk("t4_head_y", h_y, 1120);

    // 5: hold masks the reader; empty enq+deq takes only the enqueue
    clear = 1; tick(); clear = 0;
    drive_enq(1, 200); deq = 1; tick(); deq = 0;
    chk("t5_emptyenqdeq", count, 1);
    for (int i = 1; i < 4; i++) begin
      drive_enq(1, 8'(200 + i));
      tick();
    end
    drive_enq(0, 0);
    hold = 1; #1;
    chk("t5_hold_empty", is_empty, 1);
    for (int i = 0; i < 3; i++) begin
      deq = 1; tick(); deq = 0; tick();
    end
    chk("t5_hold_count", count, 4);
    hold = 0; #1;
    chk("t5_release_empty", is_empty, 0);
    chk("t5_release_head", h_id, 200);

    // 6: clear overrides enq and deq
    clear = 1; tick(); clear = 0;
    for (int i = 0; i < 7; i++) begin
      drive_enq(1, 8'(i + 30));
      tick();
    end
    chk("t6_count7", count, 7);
    clear = 1; deq = 1; drive_enq(1, 77);
    tick();
    clear = 0; deq = 0; drive_enq(0, 0);
    chk("t6_count0", count, 0);
    chk("t6_empty", is_empty, 1);
    chk("t6_ovf", overflow, 0);
    drive_enq(1, 55); tick(); drive_enq(0, 0);
    chk("t6_after_clear_head", h_id, 55);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
